// File: rtl/sec_down_stage.sv
// Seconds stage of the countdown timer: one-second prescaler, BCD 59..00 down-counter,
// borrow pulse to the minute chain and the IDLE/RUN/PAUSE/EXPIRED control FSM.
module sec_down_stage #(
   parameter int TICK_DIV = 100000000,
   parameter int DIV_W    = 27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic       min_zero,
   input  logic       min_error,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic       min_ce,
   output logic       running,
   output logic       alarm
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

   state_t           state_q;
   logic [DIV_W-1:0] presc_q;
   logic [3:0]       ones_q;
   logic [3:0]       tens_q;
   logic             ce_q;
   logic             running_q;
   logic             alarm_q;

   logic             secs_zero;
   logic             start_ok;
   logic             tick;
   logic [3:0]       ones_d;
   logic [3:0]       tens_d;
   logic             wrap_d;
   logic             expire_d;

   assign secs_zero = (ones_q == 4'd0) && (tens_q == 4'd0);
   // Refuse to start a count that is already at 00:00, or while the minute digits are bad.
   assign start_ok  = start && !pause && !min_error && !(min_zero && secs_zero);
   assign tick      = (state_q == RUN) && (presc_q == PRESC_LAST);

   // Value the seconds digits take on the next tick, plus borrow/expiry side effects.
   always_comb begin
      ones_d   = ones_q;
      tens_d   = tens_q;
      wrap_d   = 1'b0;
      expire_d = 1'b0;
      if (ones_q != 4'd0) begin
         ones_d   = ones_q - 4'd1;
         expire_d = min_zero && (tens_q == 4'd0) && (ones_q == 4'd1);
      end else if (tens_q != 4'd0) begin
         ones_d = 4'd9;
         tens_d = tens_q - 4'd1;
      end else if (min_zero) begin
         // 00 with minutes already zero: expire instead of wrapping.
         expire_d = 1'b1;
      end else begin
         ones_d = 4'd9;
         tens_d = 4'd5;
         wrap_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         ones_q    <= 4'd0;
         tens_q    <= 4'd0;
         ce_q      <= 1'b0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else if (load) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         ones_q    <= 4'd0;
         tens_q    <= 4'd0;
         ce_q      <= 1'b0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         ce_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  state_q   <= RUN;
                  presc_q   <= '0;
                  running_q <= 1'b1;
               end
            end
            PAUSE: begin
               // Resume with the prescaler where it was frozen.
               if (start_ok) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (pause) begin
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
               end else if (tick) begin
                  presc_q <= '0;
                  ones_q  <= ones_d;
                  tens_q  <= tens_d;
                  ce_q    <= wrap_d;
                  if (expire_d) begin
                     state_q   <= EXPIRED;
                     running_q <= 1'b0;
                     alarm_q   <= 1'b1;
                  end
               end else begin
                  presc_q <= presc_q + DIV_W'(1);
               end
            end
            EXPIRED: begin
               state_q <= EXPIRED;
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
               alarm_q   <= 1'b0;
            end
         endcase
      end
   end

   assign sec_ones = ones_q;
   assign sec_tens = tens_q;
   assign min_ce   = ce_q;
   assign running  = running_q;
   assign alarm    = alarm_q;

endmodule

// File: tb/tb_sec_down_stage.sv
// Directed bench for sec_down_stage: stimulus queues expected snapshots keyed by clk edge,
// a monitor process compares them on the falling edge.
module tb_sec_down_stage;

   logic       clk = 1'b0;
   logic       reset, load, start, pause, min_zero, min_error;
   logic [3:0] sec_ones, sec_tens;
   logic       min_ce, running, alarm;

   always #5 clk = ~clk;

   sec_down_stage #(.TICK_DIV(4), .DIV_W(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .start    (start),
      .pause    (pause),
      .min_zero (min_zero),
      .min_error(min_error),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .min_ce   (min_ce),
      .running  (running),
      .alarm    (alarm)
   );

   typedef struct {
      int         cyc;
      logic [3:0] tens;
      logic [3:0] ones;
      logic       ce;
      logic       run;
      logic       alm;
      int         cecnt;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   ce_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected state after edge (cyc + k); cecnt is the total min_ce-high cycles seen so far.
   task automatic expect_at(input int k, input logic [3:0] t, input logic [3:0] o,
                            input logic ce, input logic run, input logic alm,
                            input int cecnt, input string nm);
      exp_t e;
      e.cyc = cyc + k; e.tens = t; e.ones = o; e.ce = ce;
      e.run = run; e.alm = alm; e.cecnt = cecnt; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (min_ce === 1'b1) ce_seen++;
         if (!reset) begin
            checks++;
            if (!(sec_tens <= 4'd5 && sec_ones <= 4'd9)) begin
               failures++;
               $display("FAIL bcd_range cyc=%0d: got %0d%0d, required tens<=5 ones<=9",
                        cyc, sec_tens, sec_ones);
            end
         end
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               checks++;
               if (sec_tens !== sb[i].tens || sec_ones !== sb[i].ones || min_ce !== sb[i].ce ||
                   running !== sb[i].run || alarm !== sb[i].alm || ce_seen != sb[i].cecnt) begin
                  failures++;
                  $display("FAIL %s cyc=%0d: got sec=%0d%0d ce=%b run=%b alarm=%b ce_pulses=%0d, required sec=%0d%0d ce=%b run=%b alarm=%b ce_pulses=%0d",
                           sb[i].name, cyc, sec_tens, sec_ones, min_ce, running, alarm, ce_seen,
                           sb[i].tens, sb[i].ones, sb[i].ce, sb[i].run, sb[i].alm, sb[i].cecnt);
               end else begin
                  $display("check %s cyc=%0d sec=%0d%0d ce=%b run=%b alarm=%b ok",
                           sb[i].name, cyc, sec_tens, sec_ones, min_ce, running, alarm);
               end
               sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
               checks++;
               failures++;
               $display("FAIL %s: expectation for cyc=%0d never sampled (now %0d)",
                        sb[i].name, sb[i].cyc, cyc);
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, got cyc=%0d required finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
      min_zero = 1'b0; min_error = 1'b0;

      // Reset and idle
      expect_at(2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, "reset_state");
      wait_cyc(3);
      reset = 1'b0;
      expect_at(10, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, "idle_10");
      wait_cyc(10);
      start = 1'b1; min_zero = 1'b1;
      expect_at(1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, "start_blocked_mz_a");
      expect_at(3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, "start_blocked_mz_b");
      wait_cyc(3);
      start = 1'b0; min_zero = 1'b0;

      // Load, start, first wrap and full descent through BCD boundaries (tick k at edge 1+4k)
      load = 1'b1;
      wait_cyc(1);
      load = 1'b0; start = 1'b1;
      expect_at(1,   4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 0, "run_enter");
      expect_at(4,   4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 0, "pre_first_tick");
      expect_at(5,   4'd5, 4'd9, 1'b1, 1'b1, 1'b0, 1, "wrap_00_59");
      expect_at(6,   4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 1, "ce_one_cycle");
      expect_at(8,   4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 1, "hold_59");
      expect_at(9,   4'd5, 4'd8, 1'b0, 1'b1, 1'b0, 1, "dec_58");
      expect_at(13,  4'd5, 4'd7, 1'b0, 1'b1, 1'b0, 1, "dec_57");
      expect_at(41,  4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 1, "dec_50");
      expect_at(45,  4'd4, 4'd9, 1'b0, 1'b1, 1'b0, 1, "bcd_50_49");
      expect_at(201, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1, "dec_10");
      expect_at(205, 4'd0, 4'd9, 1'b0, 1'b1, 1'b0, 1, "bcd_10_09");
      expect_at(237, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1, "dec_01");
      expect_at(241, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1, "dec_00_no_ce");
      expect_at(245, 4'd5, 4'd9, 1'b1, 1'b1, 1'b0, 2, "wrap2_00_59");
      expect_at(246, 4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 2, "ce2_one_cycle");
      wait_cyc(1);
      start = 1'b0;
      wait_cyc(246);

      // Pause with prescaler at 2, hold 10 cycles including start+pause, resume
      pause = 1'b1;
      expect_at(1, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 2, "paused");
      expect_at(5, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 2, "paused_hold");
      wait_cyc(5);
      start = 1'b1;
      expect_at(1, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 2, "start_pause_stay_a");
      expect_at(5, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 2, "start_pause_stay_b");
      wait_cyc(5);
      pause = 1'b0; min_zero = 1'b1;
      expect_at(1,   4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 2, "resume");
      expect_at(2,   4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 2, "resume_hold");
      expect_at(3,   4'd5, 4'd8, 1'b0, 1'b1, 1'b0, 2, "resume_dec");
      expect_at(227, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 2, "mz_sec_02");
      expect_at(231, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2, "mz_sec_01");
      expect_at(235, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2, "expired");
      expect_at(240, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2, "expired_ignore_start");
      wait_cyc(3);
      start = 1'b0;
      wait_cyc(233);
      start = 1'b1; pause = 1'b1;
      wait_cyc(5);
      start = 1'b0; pause = 1'b0; load = 1'b1;
      expect_at(1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2, "load_clears_alarm");
      wait_cyc(1);
      load = 1'b0; start = 1'b1;
      expect_at(2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2, "idle_blocked_00_mz");
      wait_cyc(2);

      // Run again and reset at 37
      min_zero = 1'b0;
      expect_at(1,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2, "run_again");
      expect_at(93, 4'd3, 4'd7, 1'b0, 1'b1, 1'b0, 3, "at_37");
      expect_at(94, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3, "reset_mid_run");
      wait_cyc(1);
      start = 1'b0;
      wait_cyc(92);
      reset = 1'b1;
      wait_cyc(1);
      reset = 1'b0; min_error = 1'b1; start = 1'b1;
      expect_at(1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3, "min_error_blocks_a");
      expect_at(3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3, "min_error_blocks_b");
      wait_cyc(3);
      start = 1'b0; min_error = 1'b0;

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      while (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got no sample, required one at cyc=%0d", sb[0].name, sb[0].cyc);
         sb.delete(0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sec_down_stage.md
Name: sec_down_stage

Overview:
- Seconds stage of the countdown timer.
- Divides the board clock into a one-second enable and counts two BCD seconds digits down from 59 to 00.
- Emits a one-cycle borrow pulse that drives the CE input of the minute-digit down-counter chain.
- Runs a start/pause/expire FSM that uses a minutes-all-zero flag returned from the minute chain.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick; legal values ≥ 2; the bench uses 4.
- DIV_W, 27: prescaler width; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  same strobe that loads the minute digits; clears seconds, returns to IDLE.
- start  input  1  level; begin or resume counting.
- pause  input  1  level; freeze counting.
- min_zero  input  1  high when both minute digits equal 0.
- min_error  input  1  OR of minute-digit error flags; blocks start.
- sec_ones  output  4  BCD seconds ones digit, 0..9.
- sec_tens  output  4  BCD seconds tens digit, 0..5.
- min_ce  output  1  registered one-cycle borrow to the minute chain CE.
- running  output  1  high in RUN.
- alarm  output  1  high in EXPIRED.

Behaviour:
- All outputs are registered or decoded directly from state.
- Reset (priority 1): state=IDLE, prescaler=0, sec_tens=0, sec_ones=0, min_ce=0, alarm=0, running=0.
- load (priority 2, any state): seconds←00, prescaler←0, state←IDLE, alarm←0, min_ce←0.
- States: IDLE, RUN, PAUSE, EXPIRED.
- IDLE→RUN when start=1, pause=0, min_error=0 and NOT(min_zero && seconds==00). Prescaler restarts at 0.
- PAUSE→RUN under the same conditions. Prescaler resumes from its held value.
- RUN→PAUSE when pause=1. pause beats start when both are high. Prescaler and digits hold.
- start while in RUN is ignored. start while min_error=1 is ignored in every state.
- EXPIRED is exited only by load or reset. start and pause are ignored there.
- Prescaler advances only in RUN. tick = (state==RUN) && (prescaler==TICK_DIV-1). On tick the prescaler wraps to 0.
- Seconds update on the tick edge, BCD only:
  - ones≠0: ones−1.
  - ones=0, tens≠0: ones←9, tens−1.
  - 00 with min_zero=0: digits←59 and min_ce←1 for exactly one cycle.
  - The minute chain samples min_ce at the next edge, so the minute digits lag the seconds wrap by one clk.
- Expiry: on a tick edge where the new seconds value is 00 and min_zero=1, state←EXPIRED and alarm←1 on that same edge.
  - min_ce cannot pulse on that edge, so min_zero is stable.
  - The digits stay at 00.
- 00 with min_zero=1 while in RUN cannot be reached through the start guard. If it occurs anyway (minute chain reloaded externally), the next tick forces EXPIRED and does not wrap.
- min_ce is 0 in every cycle except the one following a 00→59 borrow.
- running=1 only in RUN. alarm=1 only in EXPIRED.
- Digits never leave BCD range: tens ≤5, ones ≤9.
- reset or load mid-RUN aborts the count immediately. Any pending min_ce is cancelled.

Test Plan:
- Reset, then idle 10 cycles → sec=00, min_ce=0, running=0, alarm=0. Assert start with min_zero=1 → stays IDLE.
- TICK_DIV=4, min_zero=0, load then start → running=1 at the next edge. First tick is 4 edges later: sec 00→59 with min_ce high for exactly 1 cycle. Following ticks every 4 edges give 58, 57, and min_ce stays low.
- Drive through the BCD boundaries → 50→49, 10→09, 01→00→59 (borrow only on the last step). No illegal BCD value appears.
- Pause when prescaler=2, hold 10 cycles, release → digits and prescaler frozen. Next decrement occurs 2 edges after re-entering RUN. Assert start+pause together from PAUSE → stays PAUSE.
- min_zero=1, sec=02 in RUN → 01 then 00. State is EXPIRED on the 00 edge: alarm=1, running=0, min_ce never pulses. start is ignored. load clears alarm and returns to IDLE.
- Reset asserted mid-RUN at sec=37 → all outputs zero next edge. start with min_error=1 → remains IDLE.
